seletor_terminais_rr: RTL and testbench
=======================================

# seletor_terminais_rr

Parametrised, clocked successor to the combinational terminal selector. It has N_SRC request sources competing for N_TERM shared terminals and allocates at most one free terminal per cycle, using round-robin or fixed-priority arbitration. It holds each allocation until the source releases it or a hold timeout expires. It sits between the request inputs and the terminal-enable logic and replaces the fixed two-terminal decode.

## Interface
Parameters:
- N_SRC, default 6: number of request sources (2..16).
- N_TERM, default 2: number of terminals (1..N_SRC).
- HOLD_MAX, default 0: maximum ownership length in cycles. 0 disables the timeout.
- FIXED_PRIO, default 0: 0 selects round-robin; 1 selects fixed priority, where the lowest index wins.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- req, input, N_SRC: level request per source.
- grant, output, N_SRC: source i currently owns a terminal.
- term_of, output, N_SRC*TW (TW = max(1,clog2(N_TERM))): terminal index owned by source i, in slice [i*TW +: TW]. Valid only while grant[i]=1, otherwise 0.
- term_busy, output, N_TERM: terminal t is allocated.
- timeout, output, N_SRC: one-cycle pulse when source i loses its terminal by timeout.

## Operation
- Per-terminal state is TERM_FREE or TERM_BUSY, with an owner index and a hold counter.
- Per source there is a blocked flag, which is set on timeout and cleared when req[i] is sampled low.
- Eligible source: req[i]=1, grant[i]=0, blocked[i]=0.
- Each cycle with at least one eligible source and at least one free terminal:
  - The arbiter picks one source.
  - That source gets the lowest-index free terminal.
- Round-robin: the search starts at ptr+1 modulo N_SRC. After each grant, ptr is set to the winner.
- FIXED_PRIO=1: the lowest eligible index wins and ptr is unused.
- Release: grant[i]=1 and req[i] sampled 0. The terminal goes to TERM_FREE and grant[i], term_of slice and term_busy bit clear.
- Timeout (HOLD_MAX>0):
  - The counter resets to 0 on grant and increments each owned cycle.
  - When the counter reaches HOLD_MAX-1 with req still high, the terminal is forcibly freed, timeout[i] pulses, and blocked[i] is set.
- Release and timeout in the same cycle: treated as a normal release. No timeout pulse, no block.
- If all terminals are busy, requests wait with no loss. Grant order on freeing follows the arbitration mode.

## Timing
- Reset values: grant=0, term_of=0, term_busy=0, timeout=0, ptr=N_SRC-1 (so source 0 is searched first), blocked=0, all terminals TERM_FREE.
- Reset mid-operation clears all state asynchronously. The first allocation is possible on the first edge after rst_n deasserts.
- Grant latency: req sampled high at edge k with terminal and arbitration won, then grant visible after edge k (registered, 1 cycle).
- Release latency: req sampled low at edge k, then grant and term_busy low after edge k.
- A freed terminal is not reallocated on the same edge. Earliest reuse is edge k+1.
- Ownership with HOLD_MAX=H: grant stays high for exactly H cycles. The timeout pulse coincides with the first cycle of grant low.
- A blocked source is re-eligible only after req is sampled 0 for at least one edge.
- Outputs are all registered; there are no combinational paths from req to outputs.

## Structure
- Package seletor_pkg holds:
  - enum term_state_t {TERM_FREE, TERM_BUSY}
  - the TW width helper function
  - the mode constants MODE_RR=0 and MODE_FIXED=1
- Sub-module arbitro_rr(N_SRC, FIXED_PRIO) takes an eligible vector and ptr, and returns a one-hot winner and a valid flag. It is purely combinational.
- Top level holds the terminal state array, hold counters, blocked flags, ptr and output registers.

## Test plan
- Defaults, req=6'b000011 at the same edge: one cycle later grant=000001 with term_of[0]=0. The next cycle grant=000011 with term_of[1]=1 and term_busy=11.
- All 6 requesting, N_TERM=2, each owner releasing after 3 cycles (RR): grant order is 0,1,2,3,4,5,0. No source waits more than 3 releases.
- FIXED_PRIO=1, req=111111 held, owners cycling release: sources 0 and 1 always reacquire and sources 2..5 never get a grant.
- HOLD_MAX=4, req[2] held high: grant[2] is high for 4 cycles, then timeout[2] pulses once. There is no regrant until req[2] drops for a cycle and rises again.
- Release on the same cycle as a new request from another source with all terminals busy: the new grant appears one cycle after term_busy clears, never on the same edge.
- rst_n pulsed low mid-ownership: grant, term_busy and timeout go to 0 immediately, and after release source 0 is the first granted.

Source files
------------

// File: rtl/seletor_terminais_rr_pkg.sv
// Shared types and helpers for the round-robin terminal selector.
// Imported by the interface, the arbiter and the top level.
package seletor_pkg;

    typedef enum logic {
        TERM_FREE = 1'b0,
        TERM_BUSY = 1'b1
    } term_state_t;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Index width that never collapses to zero bits (a single terminal still needs one).
    function automatic int tw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seletor_terminais_rr_if.sv
// Request/allocation bundle between the request sources and the terminal-enable logic.
// req is a level request; grant[i] stays high while source i owns slice i of term_of,
// until req[i] is sampled low or timeout[i] pulses.
interface seletor_terminais_rr_if #(
    parameter int N_SRC  = 6,
    parameter int N_TERM = 2
);
    import seletor_pkg::*;
    localparam int TW = tw_of(N_TERM);

    logic [N_SRC-1:0]    req;
    logic [N_SRC-1:0]    grant;
    logic [N_SRC*TW-1:0] term_of;
    logic [N_TERM-1:0]   term_busy;
    logic [N_SRC-1:0]    timeout;

    modport master (output req, input grant, term_of, term_busy, timeout);
    modport slave  (input req, output grant, term_of, term_busy, timeout);

endinterface

// File: rtl/seletor_terminais_rr_arbitro.sv
// Combinational single-winner arbiter: round-robin from ptr+1, or lowest index first.
module arbitro_rr
    import seletor_pkg::*;
#(
    parameter int N_SRC      = 6,
    parameter int FIXED_PRIO = MODE_RR,
    localparam int SW        = tw_of(N_SRC)
) (
    input  logic [N_SRC-1:0] elig,
    input  logic [SW-1:0]    ptr,
    output logic [N_SRC-1:0] winner,
    output logic             valid
);

    logic [SW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (FIXED_PRIO == MODE_FIXED) ? SW'(k) : SW'((int'(ptr) + 1 + k) % N_SRC);
            if (!valid && elig[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seletor_terminais_rr.sv
// Allocates at most one free terminal per cycle to the arbitration winner and holds it
// until the owner drops req or the optional hold timeout frees it.
module seletor_terminais_rr
    import seletor_pkg::*;
#(
    parameter int N_SRC      = 6,
    parameter int N_TERM     = 2,
    parameter int HOLD_MAX   = 0,
    parameter int FIXED_PRIO = MODE_RR
) (
    input logic                 clk,
    input logic                 rst_n,
    seletor_terminais_rr_if.slave bus
);

    localparam int TW = tw_of(N_TERM);
    localparam int SW = tw_of(N_SRC);
    localparam int CW = tw_of(HOLD_MAX + 1);

    term_state_t      st_q  [N_TERM];
    term_state_t      st_d  [N_TERM];
    logic [SW-1:0]    own_q [N_TERM];
    logic [SW-1:0]    own_d [N_TERM];
    logic [CW-1:0]    cnt_q [N_TERM];
    logic [CW-1:0]    cnt_d [N_TERM];
    logic [N_SRC-1:0] blocked_q, blocked_d;
    logic [N_SRC-1:0] timeout_q, timeout_d;
    logic [SW-1:0]    ptr_q, ptr_d;

    logic [N_SRC-1:0]    grant_cur;
    logic [N_SRC*TW-1:0] term_of_cur;
    logic [N_TERM-1:0]   busy_cur;
    logic [N_SRC-1:0]    elig;
    logic [N_SRC-1:0]    win_oh;
    logic                win_valid;
    logic [SW-1:0]       win_idx;
    logic                free_found;
    logic [TW-1:0]       free_idx;

    // Outputs are decoded purely from registered terminal state, so req never reaches them.
    always_comb begin
        grant_cur   = '0;
        term_of_cur = '0;
        busy_cur    = '0;
        for (int t = 0; t < N_TERM; t++) begin
            if (st_q[t] == TERM_BUSY) begin
                busy_cur[t]                   = 1'b1;
                grant_cur[own_q[t]]           = 1'b1;
                term_of_cur[own_q[t]*TW +: TW] = TW'(t);
            end
        end
    end

    assign elig = bus.req & ~grant_cur & ~blocked_q;

    arbitro_rr #(
        .N_SRC      (N_SRC),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arbitro (
        .elig   (elig),
        .ptr    (ptr_q),
        .winner (win_oh),
        .valid  (win_valid)
    );

    always_comb begin
        win_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (win_oh[i]) win_idx = SW'(i);
        end
        for (int t = 0; t < N_TERM; t++) begin
            if (!free_found && st_q[t] == TERM_FREE) begin
                free_found = 1'b1;
                free_idx   = TW'(t);
            end
        end
    end

    always_comb begin
        st_d      = st_q;
        own_d     = own_q;
        cnt_d     = cnt_q;
        blocked_d = blocked_q & bus.req;
        timeout_d = '0;
        ptr_d     = ptr_q;
        // A release wins over a simultaneous timeout, so the timeout test needs req high.
        for (int t = 0; t < N_TERM; t++) begin
            if (st_q[t] == TERM_BUSY) begin
                if (!bus.req[own_q[t]]) begin
                    st_d[t] = TERM_FREE;
                end else if (HOLD_MAX > 0 && cnt_q[t] == CW'(HOLD_MAX - 1)) begin
                    st_d[t]              = TERM_FREE;
                    timeout_d[own_q[t]]  = 1'b1;
                    blocked_d[own_q[t]]  = 1'b1;
                end else begin
                    cnt_d[t] = cnt_q[t] + 1'b1;
                end
            end
        end
        // Only terminals already free this cycle are handed out; freed ones wait an edge.
        if (win_valid && free_found) begin
            st_d[free_idx]  = TERM_BUSY;
            own_d[free_idx] = win_idx;
            cnt_d[free_idx] = '0;
            ptr_d           = win_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < N_TERM; t++) begin
                st_q[t]  <= TERM_FREE;
                own_q[t] <= '0;
                cnt_q[t] <= '0;
            end
            blocked_q <= '0;
            timeout_q <= '0;
            ptr_q     <= SW'(N_SRC - 1);
        end else begin
            st_q      <= st_d;
            own_q     <= own_d;
            cnt_q     <= cnt_d;
            blocked_q <= blocked_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.grant     = grant_cur;
    assign bus.term_of   = term_of_cur;
    assign bus.term_busy = busy_cur;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_seletor_terminais_rr.sv
// Bench for seletor_terminais_rr: three configurations (round-robin, fixed priority,
// hold timeout) compared every cycle against an ownership-level reference model.
module tb_seletor_terminais_rr;
    import seletor_pkg::*;

    localparam int NS = 6;
    localparam int NT = 2;
    localparam int NM = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    seletor_terminais_rr_if #(.N_SRC(NS), .N_TERM(NT)) if_rr ();
    seletor_terminais_rr_if #(.N_SRC(NS), .N_TERM(NT)) if_fx ();
    seletor_terminais_rr_if #(.N_SRC(NS), .N_TERM(NT)) if_to ();

    seletor_terminais_rr #(.N_SRC(NS), .N_TERM(NT), .HOLD_MAX(0), .FIXED_PRIO(0))
        dut_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr));
    seletor_terminais_rr #(.N_SRC(NS), .N_TERM(NT), .HOLD_MAX(0), .FIXED_PRIO(1))
        dut_fx (.clk(clk), .rst_n(rst_n), .bus(if_fx));
    seletor_terminais_rr #(.N_SRC(NS), .N_TERM(NT), .HOLD_MAX(4), .FIXED_PRIO(0))
        dut_to (.clk(clk), .rst_n(rst_n), .bus(if_to));

    logic [NS-1:0] req_v     [NM];
    logic [NS-1:0] d_grant   [NM];
    logic [NS-1:0] d_term_of [NM];
    logic [NT-1:0] d_busy    [NM];
    logic [NS-1:0] d_tmo     [NM];

    assign if_rr.req = req_v[0];
    assign if_fx.req = req_v[1];
    assign if_to.req = req_v[2];
    assign d_grant[0] = if_rr.grant;  assign d_term_of[0] = if_rr.term_of;
    assign d_busy[0]  = if_rr.term_busy; assign d_tmo[0]  = if_rr.timeout;
    assign d_grant[1] = if_fx.grant;  assign d_term_of[1] = if_fx.term_of;
    assign d_busy[1]  = if_fx.term_busy; assign d_tmo[1]  = if_fx.timeout;
    assign d_grant[2] = if_to.grant;  assign d_term_of[2] = if_to.term_of;
    assign d_busy[2]  = if_to.term_busy; assign d_tmo[2]  = if_to.timeout;

    // Reference model: who owns each terminal and for how many visible cycles.
    int cfg_fixed [NM] = '{0, 1, 0};
    int cfg_hold  [NM] = '{0, 0, 4};
    int m_owner   [NM][NT];
    int m_held    [NM][NT];
    bit m_blocked [NM][NS];
    bit m_tmo     [NM][NS];
    int m_ptr     [NM];

    task automatic model_reset();
        for (int m = 0; m < NM; m++) begin
            m_ptr[m] = NS - 1;
            for (int t = 0; t < NT; t++) begin
                m_owner[m][t] = -1;
                m_held[m][t]  = 0;
            end
            for (int s = 0; s < NS; s++) begin
                m_blocked[m][s] = 1'b0;
                m_tmo[m][s]     = 1'b0;
            end
        end
    endtask

    task automatic model_step(input int m, input logic [NS-1:0] r);
        bit owns [NS];
        bit elig [NS];
        int first_free;
        int win;
        int c;
        for (int s = 0; s < NS; s++) owns[s] = 1'b0;
        for (int t = 0; t < NT; t++) if (m_owner[m][t] >= 0) owns[m_owner[m][t]] = 1'b1;
        for (int s = 0; s < NS; s++) elig[s] = r[s] && !owns[s] && !m_blocked[m][s];
        first_free = -1;
        for (int t = NT - 1; t >= 0; t--) if (m_owner[m][t] < 0) first_free = t;
        for (int s = 0; s < NS; s++) begin
            m_tmo[m][s] = 1'b0;
            if (!r[s]) m_blocked[m][s] = 1'b0;
        end
        for (int t = 0; t < NT; t++) begin
            if (m_owner[m][t] >= 0) begin
                if (!r[m_owner[m][t]]) begin
                    m_owner[m][t] = -1;
                end else if (cfg_hold[m] > 0 && m_held[m][t] == cfg_hold[m]) begin
                    m_tmo[m][m_owner[m][t]]     = 1'b1;
                    m_blocked[m][m_owner[m][t]] = 1'b1;
                    m_owner[m][t] = -1;
                end else begin
                    m_held[m][t]++;
                end
            end
        end
        win = -1;
        for (int k = 1; k <= NS; k++) begin
            c = (cfg_fixed[m] != 0) ? k - 1 : (m_ptr[m] + k) % NS;
            if (win < 0 && elig[c]) win = c;
        end
        if (win >= 0 && first_free >= 0) begin
            m_owner[m][first_free] = win;
            m_held[m][first_free]  = 1;
            m_ptr[m] = win;
        end
    endtask

    function automatic logic [NS-1:0] exp_grant(input int m);
        logic [NS-1:0] g = '0;
        for (int t = 0; t < NT; t++) if (m_owner[m][t] >= 0) g[m_owner[m][t]] = 1'b1;
        return g;
    endfunction

    function automatic logic [NS-1:0] exp_term_of(input int m);
        logic [NS-1:0] v = '0;
        for (int t = 0; t < NT; t++) if (m_owner[m][t] >= 0) v[m_owner[m][t]] = (t == 1);
        return v;
    endfunction

    function automatic logic [NT-1:0] exp_busy(input int m);
        logic [NT-1:0] b = '0;
        for (int t = 0; t < NT; t++) b[t] = (m_owner[m][t] >= 0);
        return b;
    endfunction

    function automatic logic [NS-1:0] exp_tmo(input int m);
        logic [NS-1:0] v = '0;
        for (int s = 0; s < NS; s++) v[s] = m_tmo[m][s];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One clock: model advances on the edge, all DUTs are compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else for (int m = 0; m < NM; m++) model_step(m, req_v[m]);
        @(negedge clk);
        for (int m = 0; m < NM; m++) begin
            check($sformatf("dut%0d grant", m),   32'(d_grant[m]),   32'(exp_grant(m)));
            check($sformatf("dut%0d term_of", m), 32'(d_term_of[m]), 32'(exp_term_of(m)));
            check($sformatf("dut%0d busy", m),    32'(d_busy[m]),    32'(exp_busy(m)));
            check($sformatf("dut%0d timeout", m), 32'(d_tmo[m]),     32'(exp_tmo(m)));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int m = 0; m < NM; m++) req_v[m] = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [NS-1:0] req;
        logic [NS-1:0] grant;
        logic [NT-1:0] busy;
        logic [NS-1:0] term_of;
    } vec_t;

    typedef struct {
        logic [NS-1:0] req;
        logic          grant2;
        logic          tmo2;
    } hold_vec_t;

    vec_t          tbl     [10];
    hold_vec_t     hold_tbl[11];
    logic [2:0]    exp_q[$];
    int            hc [NM][NS];
    logic [NS-1:0] prev_grant;
    logic [2:0]    exp_src;

    initial begin
        tbl[0] = '{6'b000011, 6'b000001, 2'b01, 6'b000000};
        tbl[1] = '{6'b000011, 6'b000011, 2'b11, 6'b000010};
        tbl[2] = '{6'b000010, 6'b000010, 2'b10, 6'b000010};
        tbl[3] = '{6'b000110, 6'b000110, 2'b11, 6'b000010};
        tbl[4] = '{6'b000000, 6'b000000, 2'b00, 6'b000000};
        tbl[5] = '{6'b000011, 6'b000001, 2'b01, 6'b000000};
        tbl[6] = '{6'b000011, 6'b000011, 2'b11, 6'b000010};
        tbl[7] = '{6'b001010, 6'b000010, 2'b10, 6'b000010};
        tbl[8] = '{6'b001010, 6'b001010, 2'b11, 6'b000010};
        tbl[9] = '{6'b000000, 6'b000000, 2'b00, 6'b000000};
        for (int i = 0; i < 8; i++) hold_tbl[i] = '{6'b000100, (i < 4), (i == 4)};
        hold_tbl[8]  = '{6'b000000, 1'b0, 1'b0};
        hold_tbl[9]  = '{6'b000100, 1'b1, 1'b0};
        hold_tbl[10] = '{6'b000100, 1'b1, 1'b0};

        for (int m = 0; m < NM; m++) req_v[m] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int m = 0; m < NM; m++) begin
            check($sformatf("reset dut%0d grant", m),   32'(d_grant[m]),   32'h0);
            check($sformatf("reset dut%0d term_of", m), 32'(d_term_of[m]), 32'h0);
            check($sformatf("reset dut%0d busy", m),    32'(d_busy[m]),    32'h0);
            check($sformatf("reset dut%0d timeout", m), 32'(d_tmo[m]),     32'h0);
        end
        rst_n = 1'b1;

        // Directed allocation / release / reuse-latency table on the round-robin instance.
        for (int i = 0; i < 10; i++) begin
            req_v[0] = tbl[i].req;
            tick();
            check($sformatf("tbl%0d grant", i),   32'(if_rr.grant),     32'(tbl[i].grant));
            check($sformatf("tbl%0d busy", i),    32'(if_rr.term_busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d term_of", i), 32'(if_rr.term_of),   32'(tbl[i].term_of));
        end

        // Everyone requesting, owners drop req after three owned cycles.
        do_reset();
        exp_q = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        prev_grant = '0;
        for (int m = 0; m < NM; m++) for (int s = 0; s < NS; s++) hc[m][s] = 0;
        for (int c = 0; c < 30; c++) begin
            for (int m = 0; m < NM; m++)
                for (int s = 0; s < NS; s++) req_v[m][s] = (hc[m][s] >= 3) ? 1'b0 : 1'b1;
            tick();
            for (int m = 0; m < NM; m++)
                for (int s = 0; s < NS; s++) hc[m][s] = d_grant[m][s] ? hc[m][s] + 1 : 0;
            for (int s = 0; s < NS; s++) begin
                if (if_rr.grant[s] && !prev_grant[s] && exp_q.size() > 0) begin
                    exp_src = exp_q.pop_front();
                    check("rr grant order", 32'(s), 32'(exp_src));
                end
            end
            prev_grant = if_rr.grant;
            check("fixed prio low sources only", 32'(if_fx.grant[5:2]), 32'h0);
        end
        check("rr order complete", 32'(exp_q.size()), 32'h0);

        // Hold timeout and re-arm on the timeout instance.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            req_v[2] = hold_tbl[i].req;
            tick();
            check($sformatf("hold%0d grant2", i), 32'(if_to.grant[2]),   32'(hold_tbl[i].grant2));
            check($sformatf("hold%0d tmo2", i),   32'(if_to.timeout[2]), 32'(hold_tbl[i].tmo2));
        end

        // Asynchronous reset while terminals are owned.
        do_reset();
        for (int m = 0; m < NM; m++) req_v[m] = '1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < NM; m++) begin
            check($sformatf("async rst dut%0d grant", m),   32'(d_grant[m]), 32'h0);
            check($sformatf("async rst dut%0d busy", m),    32'(d_busy[m]),  32'h0);
            check($sformatf("async rst dut%0d timeout", m), 32'(d_tmo[m]),   32'h0);
        end
        @(negedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post reset first grant", 32'(if_rr.grant), 32'(6'b000001));

        // Randomized traffic on all three instances.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < NM; m++)
                for (int s = 0; s < NS; s++) req_v[m][s] = ($urandom_range(0, 99) < 80);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
